// File: rtl/imem_loader.sv
// imem_loader: splits 32-bit stream words into little-endian IMEM byte writes, holding fetch for the session.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailer word that must equal the 32-bit sum of the data words.
module imem_loader #(
  parameter int MEM_WIDTH  = 8,
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  s_valid,
  input  logic [INST_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  output logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    CKSUM = 3'd4,
    DONE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd5
  } state_t;
`endif

  localparam int EXT_W = PC_WIDTH + 2;
  localparam logic [EXT_W-1:0] DEPTH_EXT = EXT_W'(IMEM_DEPTH);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   addr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [INST_WIDTH-1:0] word_q;
  logic [1:0]            idx_q;
  logic                  err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INST_WIDTH-1:0] sum_q;
`endif

  logic [EXT_W-1:0] end_addr;
  logic             bad_range;
  logic             last_byte;
  logic             last_word;

  // End address is formed two bits wider than the PC so a huge count cannot wrap past the check
  assign end_addr  = {2'b00, addr_q} + (EXT_W'(cnt_q) << 2);
  assign bad_range = (end_addr > DEPTH_EXT) || (addr_q[1:0] != 2'b00);
  assign last_byte = (idx_q == 2'd3);
  assign last_word = (cnt_q == CNT_WIDTH'(1));

  assign hold = (state_q != IDLE);
  assign busy = (state_q != IDLE);
  assign err  = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CHECK;
      end
      CHECK: begin
        if (cnt_q == '0)    state_d = DONE;
        else if (bad_range) state_d = DONE;
        else                state_d = WAIT;
      end
      WAIT: begin
        s_ready = 1'b1;
        if (s_valid) state_d = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q + PC_WIDTH'(idx_q);
        mem_wdata = word_q[{idx_q, 3'b000} +: MEM_WIDTH];
        if (last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = last_word ? CKSUM : WAIT;
`else
          state_d = last_word ? DONE : WAIT;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CKSUM: begin
        s_ready = 1'b1;
        if (s_valid) state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Session datapath: address/count bookkeeping, word capture and the sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            cnt_q  <= word_count;
            err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q  <= '0;
`endif
          end
        end
        CHECK: begin
          if ((cnt_q != '0) && bad_range) err_q <= 1'b1;
        end
        WAIT: begin
          if (s_valid) begin
            word_q <= s_data;
            idx_q  <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q  <= sum_q + s_data;
`endif
          end
        end
        WRITE: begin
          idx_q <= idx_q + 2'd1;
          if (last_byte) begin
            addr_q <= addr_q + PC_WIDTH'(4);
            cnt_q  <= cnt_q - CNT_WIDTH'(1);
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CKSUM: begin
          if (s_valid && (s_data != sum_q)) err_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum cases build only with IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  tbmem [0:1023];
  logic [31:0] words [0:3];

  int   done_cycle;
  int   first_ready;
  int   write_cnt;
  int   overlap;
  int   hold_bad;
  int   oob;
  logic err_at_done;
  logic busy_after;
  logic err_after;
  logic hold_before;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({s_ready, mem_we, mem_addr, mem_wdata, hold, busy, done, err});
  endfunction

  function automatic logic [31:0] rd32(input logic [9:0] a);
    return {tbmem[a + 10'd3], tbmem[a + 10'd2], tbmem[a + 10'd1], tbmem[a]};
  endfunction

  task automatic clear_mem;
    for (int i = 0; i < 1024; i++) tbmem[i] = 8'h00;
  endtask

  // One load session: start, feed words with optional stalls, optional stray start, optional mid-cycle reset
  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] count, input int nwords,
                               input int stall, input int pulse_cycle, input int abort_cycle);
    int   widx;
    int   stall_left;
    logic accept;
    logic aborted;
    widx        = 0;
    stall_left  = stall;
    aborted     = 1'b0;
    done_cycle  = -1;
    first_ready = -1;
    write_cnt   = 0;
    overlap     = 0;
    hold_bad    = 0;
    oob         = 0;
    err_at_done = 1'bx;
    clear_mem();
    hold_before = hold;
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    step();
    for (int cyc = 1; cyc <= 100; cyc++) begin
      start = (cyc == pulse_cycle);
      if (start) begin
        base_addr  = 32'h200;
        word_count = 16'd0;
      end
      if (cyc == abort_cycle) begin
        #2 reset = 1'b1;
        #1;
        aborted = 1'b1;
        break;
      end
      if ((busy !== hold) || (hold !== 1'b1)) hold_bad++;
      if (s_ready && (first_ready < 0)) first_ready = cyc;
      if (s_ready && mem_we) overlap++;
      if (mem_we) begin
        write_cnt++;
        if (mem_addr < 32'd1024) tbmem[mem_addr[9:0]] = mem_wdata;
        else oob++;
      end
      if (done) begin
        done_cycle  = cyc;
        err_at_done = err;
        break;
      end
      s_valid = (stall_left == 0) && (widx < nwords);
      s_data  = s_valid ? words[widx] : 32'hDEAD_BEEF;
      if (s_ready && (stall_left > 0)) stall_left--;
      accept = s_valid && s_ready;
      step();
      if (accept) begin
        widx++;
        stall_left = stall;
      end
    end
    s_valid = 1'b0;
    if (!aborted) begin
      step();
      start      = 1'b0;
      busy_after = busy;
      err_after  = err;
    end
    start = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    step();
    step();
    checkOutput("reset_outputs", outs_vec(), 64'd0);
    reset = 1'b0;
    step();

    // Reset in the second cycle of word 2's WRITE (cycle 9): word 1 and byte 0 of word 2 land
    words[0] = 32'h1122_3344;
    words[1] = 32'hAABB_CCDD;
    words[2] = 32'h5566_7788;
    applyStimulus(32'h40, 16'd3, 3, 0, -1, 9);
    checkOutput("abort_outputs_async", outs_vec(), 64'd0);
    checkOutput("abort_write_cnt", 64'(write_cnt), 64'd5);
    checkOutput("abort_word1", 64'(rd32(10'h40)), 64'h1122_3344);
    checkOutput("abort_partial", 64'({tbmem[10'h45], tbmem[10'h44]}), 64'h00DD);
    checkOutput("abort_no_done", 64'(done_cycle), 64'(-1));
    step();
    step();
    checkOutput("abort_held_outputs", outs_vec(), 64'd0);
    reset = 1'b0;
    step();

    // Basic: CHECK(1), WAIT(2), WRITE(3-6), WAIT(7), WRITE(8-11), DONE(12); start re-pulsed in DONE is ignored
    words[0] = 32'h1122_3344;
    words[1] = 32'hAABB_CCDD;
    applyStimulus(32'h10, 16'd2, 2, 0, 12, -1);
    checkOutput("basic_hold_before", 64'(hold_before), 64'd0);
    checkOutput("basic_done_cycle", 64'(done_cycle), 64'd12);
    checkOutput("basic_first_ready", 64'(first_ready), 64'd2);
    checkOutput("basic_write_cnt", 64'(write_cnt), 64'd8);
    checkOutput("basic_bytes", {32'(rd32(10'h14)), 32'(rd32(10'h10))}, 64'hAABB_CCDD_1122_3344);
    checkOutput("basic_overlap", 64'(overlap), 64'd0);
    checkOutput("basic_hold", 64'(hold_bad), 64'd0);
    checkOutput("basic_err", 64'(err_at_done), 64'd0);
    checkOutput("basic_done_start_ignored", 64'(busy_after), 64'd0);

    // Three idle WAIT cycles before each word add six cycles
    applyStimulus(32'h10, 16'd2, 2, 3, -1, -1);
    checkOutput("stall_done_cycle", 64'(done_cycle), 64'd18);
    checkOutput("stall_write_cnt", 64'(write_cnt), 64'd8);
    checkOutput("stall_bytes", {32'(rd32(10'h14)), 32'(rd32(10'h10))}, 64'hAABB_CCDD_1122_3344);
    checkOutput("stall_overlap", 64'(overlap), 64'd0);
    checkOutput("stall_hold", 64'(hold_bad), 64'd0);

    // A start pulse mid-WRITE must not disturb the session
    applyStimulus(32'h10, 16'd2, 2, 0, 4, -1);
    checkOutput("midstart_done_cycle", 64'(done_cycle), 64'd12);
    checkOutput("midstart_write_cnt", 64'(write_cnt), 64'd8);
    checkOutput("midstart_bytes", {32'(rd32(10'h14)), 32'(rd32(10'h10))}, 64'hAABB_CCDD_1122_3344);

    // Exactly fills the top of IMEM: 0x3F8 + 8 = 0x400
    applyStimulus(32'h3F8, 16'd2, 2, 0, -1, -1);
    checkOutput("edge_done_cycle", 64'(done_cycle), 64'd12);
    checkOutput("edge_err", 64'(err_at_done), 64'd0);
    checkOutput("edge_bytes", {32'(rd32(10'h3FC)), 32'(rd32(10'h3F8))}, 64'hAABB_CCDD_1122_3344);
    checkOutput("edge_oob", 64'(oob), 64'd0);

    // 0x3F8 + 12 = 0x404 overruns
    words[2] = 32'h5566_7788;
    applyStimulus(32'h3F8, 16'd3, 3, 0, -1, -1);
    checkOutput("bounds_done_cycle", 64'(done_cycle), 64'd2);
    checkOutput("bounds_write_cnt", 64'(write_cnt), 64'd0);
    checkOutput("bounds_err", 64'(err_at_done), 64'd1);
    checkOutput("bounds_ready", 64'(first_ready), 64'(-1));
    step();
    step();
    checkOutput("bounds_err_sticky", 64'(err), 64'd1);

    applyStimulus(32'h11, 16'd1, 1, 0, -1, -1);
    checkOutput("unaligned_done_cycle", 64'(done_cycle), 64'd2);
    checkOutput("unaligned_write_cnt", 64'(write_cnt), 64'd0);
    checkOutput("unaligned_err", 64'(err_after), 64'd1);

    // Would wrap a 32-bit adder back into range
    applyStimulus(32'hFFFF_FFFC, 16'd1, 1, 0, -1, -1);
    checkOutput("wrap_err", 64'(err_at_done), 64'd1);
    checkOutput("wrap_write_cnt", 64'(write_cnt), 64'd0);

    // Zero count also clears the error left by the previous session
    applyStimulus(32'h10, 16'd0, 0, 0, -1, -1);
    checkOutput("zero_done_cycle", 64'(done_cycle), 64'd2);
    checkOutput("zero_write_cnt", 64'(write_cnt), 64'd0);
    checkOutput("zero_err", 64'(err_at_done), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 0xFFFFFFFF + 2 wraps to 1; CKSUM adds one cycle before DONE
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'h0000_0002;
    words[2] = 32'h0000_0001;
    applyStimulus(32'h20, 16'd2, 3, 0, -1, -1);
    checkOutput("cksum_good_done_cycle", 64'(done_cycle), 64'd13);
    checkOutput("cksum_good_err", 64'(err_at_done), 64'd0);
    checkOutput("cksum_good_write_cnt", 64'(write_cnt), 64'd8);
    checkOutput("cksum_good_bytes", {32'(rd32(10'h24)), 32'(rd32(10'h20))}, 64'h0000_0002_FFFF_FFFF);
    words[2] = 32'h0000_0002;
    applyStimulus(32'h20, 16'd2, 3, 0, -1, -1);
    checkOutput("cksum_bad_err", 64'(err_at_done), 64'd1);
    checkOutput("cksum_bad_write_cnt", 64'(write_cnt), 64'd8);
    checkOutput("cksum_bad_bytes", {32'(rd32(10'h24)), 32'(rd32(10'h20))}, 64'h0000_0002_FFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
